// File: rtl/io_result_uart_tx.sv
// Result-word UART transmitter: stages a core result word, splits it into bytes
// through a byte FIFO and serialises them as 8N1, LSB first.
module io_result_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] status,
    input  logic [31:0] result_bytes,
    output logic        txd,
    output logic        io_stall,
    output logic        overflow,
    output logic        tx_idle,
    output logic        all_done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   FIFO_FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    logic strobe;
    logic unused_status_bits;

    logic        vld_p0;
    logic [31:0] word_p0;
    logic [1:0]  last_p0;
    logic [1:0]  idx_p0;
    logic [7:0]  push_byte;

    logic [7:0]    mem_p1 [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_p1;
    logic [AW-1:0] rd_ptr_p1;
    logic [AW:0]   count_p1;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    tx_state_t     state_p2;
    logic [BW-1:0] baud_p2;
    logic [2:0]    bit_idx_p2;
    logic [7:0]    shift_p2;
    logic          baud_done;

    assign strobe             = status[0];
    assign unused_status_bits = ^status[30:3];

    // Stage 0: staging register holding the word until all its bytes are pushed
    assign push_byte = word_p0[{idx_p0, 3'b000} +: 8];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0   <= 1'b0;
            idx_p0   <= 2'd0;
            overflow <= 1'b0;
        end else begin
            if (strobe && vld_p0)
                overflow <= 1'b1;
            if (vld_p0) begin
                if (push) begin
                    idx_p0 <= idx_p0 + 2'd1;
                    if (idx_p0 == last_p0)
                        vld_p0 <= 1'b0;
                end
            end else if (strobe) begin
                vld_p0 <= 1'b1;
                idx_p0 <= 2'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!vld_p0 && strobe) begin
            word_p0 <= result_bytes;
            last_p0 <= status[2:1];
        end
    end

    // Stage 1: byte FIFO ring
    assign fifo_empty = (count_p1 == '0);
    assign fifo_full  = (count_p1 == FIFO_FULL_CNT);
    assign push       = vld_p0 && !fifo_full;
    assign pop        = (state_p2 == IDLE) && !fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_p1 <= '0;
            rd_ptr_p1 <= '0;
            count_p1  <= '0;
        end else begin
            if (push)
                wr_ptr_p1 <= wr_ptr_p1 + AW'(1);
            if (pop)
                rd_ptr_p1 <= rd_ptr_p1 + AW'(1);
            case ({push, pop})
                2'b10:   count_p1 <= count_p1 + (AW + 1)'(1);
                2'b01:   count_p1 <= count_p1 - (AW + 1)'(1);
                default: count_p1 <= count_p1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_p1[wr_ptr_p1] <= push_byte;
    end

    // Stage 2: serialiser; txd is registered and updated alongside each state change
    assign baud_done = (baud_p2 == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_p2   <= IDLE;
            baud_p2    <= '0;
            bit_idx_p2 <= 3'd0;
            txd        <= 1'b1;
        end else begin
            case (state_p2)
                IDLE: begin
                    txd <= 1'b1;
                    if (pop) begin
                        state_p2 <= START;
                        baud_p2  <= '0;
                        txd      <= 1'b0;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud_p2    <= '0;
                        bit_idx_p2 <= 3'd0;
                        state_p2   <= DATA;
                        txd        <= shift_p2[0];
                    end else begin
                        baud_p2 <= baud_p2 + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_p2 <= '0;
                        if (bit_idx_p2 == 3'd7) begin
                            state_p2 <= STOP;
                            txd      <= 1'b1;
                        end else begin
                            bit_idx_p2 <= bit_idx_p2 + 3'd1;
                            txd        <= shift_p2[1];
                        end
                    end else begin
                        baud_p2 <= baud_p2 + BW'(1);
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud_p2  <= '0;
                        state_p2 <= IDLE;
                    end else begin
                        baud_p2 <= baud_p2 + BW'(1);
                    end
                end
                default: state_p2 <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (pop)
            shift_p2 <= mem_p1[rd_ptr_p1];
        else if (state_p2 == DATA && baud_done)
            shift_p2 <= {1'b0, shift_p2[7:1]};
    end

    assign io_stall = vld_p0;
    assign tx_idle  = fifo_empty && (state_p2 == IDLE);
    assign all_done = status[31] && !vld_p0 && tx_idle;

endmodule

// File: tb/tb_io_result_uart_tx.sv
// Directed bench for io_result_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4; a passive
// receiver records every frame as 40 per-cycle txd samples plus its start cycle.
module tb_io_result_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] status = 32'h0;
    logic [31:0] result_bytes = 32'h0;
    logic        txd;
    logic        io_stall;
    logic        overflow;
    logic        tx_idle;
    logic        all_done;

    io_result_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .status(status), .result_bytes(result_bytes),
        .txd(txd), .io_stall(io_stall), .overflow(overflow),
        .tx_idle(tx_idle), .all_done(all_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vec  = 0;
    int miss = 0;

    logic [39:0] fq[$];
    int          tq[$];
    logic [39:0] mon_w;
    int          mon_t0;

    always begin
        @(posedge clk); #1;
        if (txd === 1'b0) begin
            mon_t0 = cyc;
            mon_w  = '0;
            for (int i = 0; i < 40; i++) begin
                if (i > 0) begin @(posedge clk); #1; end
                mon_w[i] = txd;
            end
            fq.push_back(mon_w);
            tq.push_back(mon_t0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [39:0] frame_of(input logic [7:0] b);
        logic [39:0] w;
        for (int i = 0; i < 40; i++) begin
            if (i < 4)       w[i] = 1'b0;
            else if (i < 36) w[i] = b[(i - 4) / 4];
            else             w[i] = 1'b1;
        end
        return w;
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic step_until(input int t);
        while (cyc < t) step();
    endtask

    task automatic wait_frames(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (fq.size() >= n) break;
            step();
        end
        if (fq.size() >= n) ok = 1'b1;
    endtask

    task automatic clear_rx();
        fq.delete();
        tq.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; status = 32'h0;
        repeat (3) step();
        vec++; if (txd !== 1'b1) begin miss++; $display("FAIL reset_txd: got %b want 1", txd); end
        vec++; if (io_stall !== 1'b0) begin miss++; $display("FAIL reset_stall: got %b want 0", io_stall); end
        vec++; if (overflow !== 1'b0) begin miss++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        vec++; if (tx_idle !== 1'b1) begin miss++; $display("FAIL reset_tx_idle: got %b want 1", tx_idle); end
        vec++; if (all_done !== 1'b0) begin miss++; $display("FAIL reset_all_done_lo: got %b want 0", all_done); end
        status = 32'h8000_0000; #1;
        vec++; if (all_done !== 1'b1) begin miss++; $display("FAIL reset_all_done_halt: got %b want 1", all_done); end
        rst = 1'b0; status = 32'h0;
        step();
    endtask

    task automatic test_single();
        int t0; bit ok;
        clear_rx();
        status = 32'h1; result_bytes = 32'h0000_00A5;
        step(); t0 = cyc; status = 32'h0;
        vec++; if (io_stall !== 1'b1) begin miss++; $display("FAIL single_stall_e0: got %b want 1", io_stall); end
        step();
        vec++; if (io_stall !== 1'b0) begin miss++; $display("FAIL single_stall_e1: got %b want 0", io_stall); end
        vec++; if (txd !== 1'b1) begin miss++; $display("FAIL single_txd_e1: got %b want 1", txd); end
        step();
        vec++; if (txd !== 1'b0) begin miss++; $display("FAIL single_txd_e2: got %b want 0", txd); end
        step_until(t0 + 41);
        vec++; if (tx_idle !== 1'b0) begin miss++; $display("FAIL single_busy_stop: got %b want 0", tx_idle); end
        step();
        vec++; if (tx_idle !== 1'b1) begin miss++; $display("FAIL single_idle_after: got %b want 1", tx_idle); end
        wait_frames(1, 10, ok);
        vec++; if (ok !== 1'b1) begin miss++; $display("FAIL single_frame_seen: got %0d frames want 1", fq.size()); end
        if (fq.size() > 0) begin
            vec++; if (fq[0] !== frame_of(8'hA5)) begin miss++; $display("FAIL single_frame: got %h want %h", fq[0], frame_of(8'hA5)); end
            vec++; if (tq[0] !== t0 + 2) begin miss++; $display("FAIL single_latency: got %0d want %0d", tq[0], t0 + 2); end
        end
    endtask

    task automatic test_four_bytes();
        int t0; bit ok; logic [4:0] sv;
        logic [7:0] exp_b [4];
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        clear_rx();
        status = 32'h7; result_bytes = 32'h4433_2211;
        step(); t0 = cyc; status = 32'h0;
        for (int k = 0; k < 5; k++) begin
            sv[k] = io_stall;
            if (k < 4) step();
        end
        vec++; if (sv !== 5'b01111) begin miss++; $display("FAIL four_stall_profile: got %b want 01111", sv); end
        wait_frames(4, 220, ok);
        vec++; if (ok !== 1'b1) begin miss++; $display("FAIL four_frames_seen: got %0d want 4", fq.size()); end
        for (int k = 0; k < 4; k++) begin
            if (k < fq.size()) begin
                vec++; if (fq[k] !== frame_of(exp_b[k])) begin miss++; $display("FAIL four_frame%0d: got %h want %h", k, fq[k], frame_of(exp_b[k])); end
                vec++; if (tq[k] !== t0 + 2 + 41 * k) begin miss++; $display("FAIL four_start%0d: got %0d want %0d", k, tq[k], t0 + 2 + 41 * k); end
            end
        end
        step_until(t0 + 2 + 123 + 41);
        vec++; if (tx_idle !== 1'b1) begin miss++; $display("FAIL four_idle_after: got %b want 1", tx_idle); end
    endtask

    task automatic test_fifo_wrap();
        int t0; int g; bit ok;
        logic [7:0] exp_b [8];
        exp_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h55, 8'h66, 8'h77, 8'h88};
        clear_rx();
        status = 32'h7; result_bytes = 32'hDDCC_BBAA;
        step(); t0 = cyc; status = 32'h0;
        g = 0;
        while (io_stall === 1'b1 && g < 10) begin step(); g++; end
        vec++; if (cyc !== t0 + 4) begin miss++; $display("FAIL wrap_first_drain: stall fell at %0d want %0d", cyc, t0 + 4); end
        status = 32'h7; result_bytes = 32'h8877_6655;
        step(); status = 32'h0;
        step_until(t0 + 42);
        vec++; if (io_stall !== 1'b1) begin miss++; $display("FAIL wrap_stall_held: got %b want 1", io_stall); end
        wait_frames(8, 420, ok);
        vec++; if (ok !== 1'b1) begin miss++; $display("FAIL wrap_frames_seen: got %0d want 8", fq.size()); end
        for (int k = 0; k < 8; k++) begin
            if (k < fq.size()) begin
                vec++; if (fq[k] !== frame_of(exp_b[k])) begin miss++; $display("FAIL wrap_frame%0d: got %h want %h", k, fq[k], frame_of(exp_b[k])); end
                vec++; if (tq[k] !== t0 + 2 + 41 * k) begin miss++; $display("FAIL wrap_start%0d: got %0d want %0d", k, tq[k], t0 + 2 + 41 * k); end
            end
        end
        step();
        vec++; if (io_stall !== 1'b0) begin miss++; $display("FAIL wrap_stall_end: got %b want 0", io_stall); end
        vec++; if (tx_idle !== 1'b1) begin miss++; $display("FAIL wrap_idle_end: got %b want 1", tx_idle); end
    endtask

    task automatic test_overflow();
        int t0; bit ok;
        clear_rx();
        vec++; if (overflow !== 1'b0) begin miss++; $display("FAIL ovf_initial: got %b want 0", overflow); end
        status = 32'h3; result_bytes = 32'h0000_5A3C;
        step(); t0 = cyc; status = 32'h0;
        step();
        vec++; if (overflow !== 1'b0 || io_stall !== 1'b1) begin miss++; $display("FAIL ovf_before: got ovf=%b stall=%b want ovf=0 stall=1", overflow, io_stall); end
        status = 32'h1; result_bytes = 32'hFFFF_FFE7;
        step(); status = 32'h0;
        vec++; if (overflow !== 1'b1) begin miss++; $display("FAIL ovf_set: got %b want 1", overflow); end
        vec++; if (io_stall !== 1'b0) begin miss++; $display("FAIL ovf_staging_drained: got %b want 0", io_stall); end
        wait_frames(2, 150, ok);
        repeat (60) step();
        vec++; if (fq.size() !== 2) begin miss++; $display("FAIL ovf_frame_count: got %0d want 2", fq.size()); end
        if (fq.size() >= 2) begin
            vec++; if (fq[0] !== frame_of(8'h3C)) begin miss++; $display("FAIL ovf_frame0: got %h want %h", fq[0], frame_of(8'h3C)); end
            vec++; if (fq[1] !== frame_of(8'h5A)) begin miss++; $display("FAIL ovf_frame1: got %h want %h", fq[1], frame_of(8'h5A)); end
            vec++; if (tq[1] !== t0 + 43) begin miss++; $display("FAIL ovf_start1: got %0d want %0d", tq[1], t0 + 43); end
        end
        vec++; if (overflow !== 1'b1) begin miss++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_halt();
        int t0; bit ok;
        clear_rx();
        status = 32'h3; result_bytes = 32'h0000_C381;
        step(); t0 = cyc; status = 32'h8000_0000;
        vec++; if (all_done !== 1'b0) begin miss++; $display("FAIL halt_done_staged: got %b want 0", all_done); end
        step_until(t0 + 40);
        vec++; if (all_done !== 1'b0) begin miss++; $display("FAIL halt_done_frame0: got %b want 0", all_done); end
        step_until(t0 + 82);
        vec++; if (all_done !== 1'b0) begin miss++; $display("FAIL halt_done_last_stop: got %b want 0", all_done); end
        step();
        vec++; if (all_done !== 1'b1) begin miss++; $display("FAIL halt_done_after: got %b want 1", all_done); end
        wait_frames(2, 10, ok);
        vec++; if (ok !== 1'b1) begin miss++; $display("FAIL halt_frames_seen: got %0d want 2", fq.size()); end
        if (fq.size() >= 2) begin
            vec++; if (fq[0] !== frame_of(8'h81)) begin miss++; $display("FAIL halt_frame0: got %h want %h", fq[0], frame_of(8'h81)); end
            vec++; if (fq[1] !== frame_of(8'hC3)) begin miss++; $display("FAIL halt_frame1: got %h want %h", fq[1], frame_of(8'hC3)); end
        end
        status = 32'h0;
        step();
    endtask

    task automatic test_reset_mid_frame();
        int t0; int lows;
        clear_rx();
        status = 32'h7; result_bytes = 32'h0F0E_0D0C;
        step(); t0 = cyc; status = 32'h0;
        step_until(t0 + 18);
        rst = 1'b1;
        step();
        vec++; if (txd !== 1'b1) begin miss++; $display("FAIL rstmid_txd: got %b want 1", txd); end
        vec++; if (tx_idle !== 1'b1) begin miss++; $display("FAIL rstmid_tx_idle: got %b want 1", tx_idle); end
        vec++; if (io_stall !== 1'b0) begin miss++; $display("FAIL rstmid_stall: got %b want 0", io_stall); end
        vec++; if (overflow !== 1'b0) begin miss++; $display("FAIL rstmid_overflow: got %b want 0", overflow); end
        rst = 1'b0;
        step_until(t0 + 70);
        clear_rx();
        lows = 0;
        repeat (150) begin
            step();
            if (txd !== 1'b1) lows++;
        end
        vec++; if (lows !== 0) begin miss++; $display("FAIL rstmid_txd_quiet: got %0d low cycles want 0", lows); end
        vec++; if (fq.size() !== 0) begin miss++; $display("FAIL rstmid_no_frames: got %0d want 0", fq.size()); end
        vec++; if (tx_idle !== 1'b1) begin miss++; $display("FAIL rstmid_idle_end: got %b want 1", tx_idle); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_four_bytes();
        test_fifo_wrap();
        test_overflow();
        test_halt();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
